// File: rtl/alu8_seq_ctrl.sv
// Multi-cycle 8-bit ALU sequencer: nibble-chained ADD/SUB, shift-add MUL, restoring DIV.
// One command in flight; the result is held in DONE until the consumer accepts it.
module alu8_seq_ctrl #(
  parameter logic [7:0] DIV0_QUOT     = 8'hFF,
  parameter int         MUL_DIV_ITERS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [3:0]  opcode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        carry_out,
  output logic [7:0]  remainder,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, ITER, DONE} state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_MUL = 4'd5;
  localparam logic [3:0] OP_DIV = 4'd6;
  localparam logic [3:0] LAST_ITER = 4'(MUL_DIV_ITERS - 1);

  state_t      state, state_nxt;
  logic [7:0]  a_q, b_q;
  logic [3:0]  op_q;
  logic [3:0]  cnt;
  logic [15:0] prod;
  logic [3:0]  lo_nib;
  logic        c_lo;

  logic        accept;
  logic        is_sub;
  logic [7:0]  b_eff;
  logic [4:0]  lo_sum, hi_sum;
  logic [8:0]  mul_sum;
  logic [15:0] mul_nxt;
  logic        div_ge;
  logic [7:0]  div_rem;
  logic [15:0] div_nxt;
  logic [15:0] iter_nxt;
  logic        direct;
  logic [7:0]  direct_res;
  logic [7:0]  direct_rem;
  logic        direct_err;

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // SUB is A + ~B + 1, so the low nibble's carry-in is the SUB flag itself.
  always_comb begin
    is_sub = (op_q == OP_SUB);
    b_eff  = is_sub ? ~b_q : b_q;
    lo_sum = {1'b0, a_q[3:0]} + {1'b0, b_eff[3:0]} + {4'b0, is_sub};
    hi_sum = {1'b0, a_q[7:4]} + {1'b0, b_eff[7:4]} + {4'b0, c_lo};
  end

  // prod holds {partial product, multiplier} for MUL and {partial remainder, quotient} for DIV.
  always_comb begin
    mul_sum  = {1'b0, prod[15:8]} + (prod[0] ? {1'b0, a_q} : 9'd0);
    mul_nxt  = {mul_sum, prod[7:1]};
    div_ge   = (prod[15:7] >= {1'b0, b_q});
    div_rem  = prod[14:7] - b_q;
    div_nxt  = div_ge ? {div_rem, prod[6:0], 1'b1} : {prod[14:0], 1'b0};
    iter_nxt = (op_q == OP_DIV) ? div_nxt : mul_nxt;
  end

  always_comb begin
    direct     = 1'b1;
    direct_res = 8'h00;
    direct_rem = 8'h00;
    direct_err = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_MUL: direct = 1'b0;
      OP_AND: direct_res = A & B;
      OP_OR:  direct_res = A | B;
      OP_XOR: direct_res = A ^ B;
      OP_DIV: begin
        direct     = (B == 8'h00);
        direct_res = DIV0_QUOT;
        direct_rem = A;
        direct_err = 1'b1;
      end
      default: direct_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (direct)                                     state_nxt = DONE;
          else if (opcode == OP_ADD || opcode == OP_SUB)  state_nxt = LOW;
          else                                            state_nxt = ITER;
        end
      end
      LOW:  state_nxt = HIGH;
      HIGH: state_nxt = DONE;
      ITER: if (cnt == LAST_ITER) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      op_q      <= 4'h0;
      cnt       <= 4'h0;
      prod      <= 16'h0000;
      lo_nib    <= 4'h0;
      c_lo      <= 1'b0;
      result    <= 16'h0000;
      carry_out <= 1'b0;
      remainder <= 8'h00;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= opcode;
            cnt  <= 4'h0;
            prod <= {8'h00, (opcode == OP_DIV) ? A : B};
            if (direct) begin
              result    <= {8'h00, direct_res};
              carry_out <= 1'b0;
              remainder <= direct_rem;
              err       <= direct_err;
            end
          end
        end
        LOW: begin
          lo_nib <= lo_sum[3:0];
          c_lo   <= lo_sum[4];
        end
        HIGH: begin
          result    <= {8'h00, hi_sum[3:0], lo_nib};
          carry_out <= is_sub ? ~hi_sum[4] : hi_sum[4];
          remainder <= 8'h00;
          err       <= 1'b0;
        end
        ITER: begin
          prod <= iter_nxt;
          cnt  <= cnt + 4'd1;
          if (cnt == LAST_ITER) begin
            err <= 1'b0;
            if (op_q == OP_DIV) begin
              result    <= {8'h00, iter_nxt[7:0]};
              remainder <= iter_nxt[15:8];
              carry_out <= 1'b0;
            end else begin
              result    <= iter_nxt;
              remainder <= 8'h00;
              carry_out <= |iter_nxt[15:8];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu8_seq_ctrl.md
Name: alu8_seq_ctrl

Overview:
- Multi-cycle sequencer that accepts one 8-bit ALU command at a time through a valid/ready handshake.
- Executes each command with a narrow iterative datapath:
  - nibble-chained ADD/SUB with carry propagated from the low nibble to the high nibble;
  - shift-add multiply;
  - restoring divide.
- Returns the 16-bit result, carry and remainder through a second valid/ready handshake.
- Sits between the instruction/issue logic and the 8-bit ALU path, supplying the carry chaining and multiply/divide sequencing that the nibble-split datapath lacks.

Parameters:
- DIV0_QUOT, 8'hFF, quotient returned on divide-by-zero.
- MUL_DIV_ITERS, 8, shift-add/restoring iterations; must equal operand width (8); other values unsupported.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  command valid.
- in_ready  output  1  controller can accept a command.
- A  input  8  operand A, sampled on accept.
- B  input  8  operand B, sampled on accept.
- opcode  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 DIV, 7-15 illegal.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  16  operation result.
- carry_out  output  1  carry/borrow/overflow flag.
- remainder  output  8  DIV remainder, else 0.
- err  output  1  divide-by-zero or illegal opcode.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; in_ready=1; out_valid=0; result=0; carry_out=0; remainder=0; err=0.
  - Reset aborts any in-flight op; no result is produced for it.
- States: IDLE, LOW, HIGH, ITER, DONE.
- Accept: in_valid&in_ready at an edge (in_ready=1 only in IDLE).
  - A, B, opcode are latched; later input changes are ignored.
- Transitions from IDLE on accept:
  - ADD/SUB -> LOW.
  - MUL/DIV with B!=0 -> ITER, iteration count=0.
  - AND/OR/XOR, illegal opcode, DIV with B=0 -> DONE directly.
- LOW: computes low nibble plus carry-in (0 for ADD, 1 for SUB with B inverted); latches nibble and carry; -> HIGH.
- HIGH: computes high nibble with the latched carry; -> DONE.
- ITER: one iteration per cycle; after the 8th iteration -> DONE.
  - MUL: shift-add, LSB first, over a 16-bit product register.
  - DIV: restoring, MSB first, over an 8-bit partial remainder.
- DONE: out_valid=1; result, carry_out, remainder and err are held stable until out_valid&out_ready, then -> IDLE.
  - in_ready=1 from the cycle after the transfer; a command cannot be accepted in the same cycle as the transfer.
- Latency, counted as edges from the accept edge to the edge where out_valid rises:
  - logic, illegal, DIV-by-0: 1.
  - ADD/SUB: 3.
  - MUL/DIV: 9.
- Result rules (result[15:8]=0 unless stated):
  - ADD: result[7:0]=A+B mod 256; carry_out=bit 8 of the sum.
  - SUB: result[7:0]=A-B mod 256; carry_out=1 iff A<B (borrow).
  - AND/OR/XOR: bitwise; carry_out=0.
  - MUL: result=A*B (full 16 bits); carry_out=|result[15:8].
  - DIV: result[7:0]=A/B, remainder=A%B; carry_out=0.
  - DIV with B=0: result={8'h00,DIV0_QUOT}; remainder=A; err=1.
  - Illegal opcode: result=0; remainder=0; carry_out=0; err=1.
- err=0 for all legal, non-faulting ops.
- Outputs other than out_valid/in_ready keep their last value when not in DONE. Checkers sample them only when out_valid=1.
- in_valid held high across busy cycles: the command is accepted only once the controller returns to IDLE.

Test Plan:
- ADD A=8'hFF, B=8'h01, out_ready=1 -> 3 edges after accept: out_valid=1, result=16'h0000, carry_out=1, err=0.
- SUB A=8'h10, B=8'h20 -> result=16'h00F0, carry_out=1; then SUB A=8'h20, B=8'h10 -> result=16'h0010, carry_out=0.
- MUL A=8'hFF, B=8'hFF -> 9 edges after accept: result=16'hFE01, carry_out=1; MUL A=8'h0C, B=8'h0A -> result=16'h0078, carry_out=0.
- DIV A=8'd200, B=8'd7 -> result=16'h001C, remainder=8'h04, err=0. DIV A=8'h55, B=0 -> 1 edge after accept: result=16'h00FF, remainder=8'h55, err=1. Opcode 4'hA -> result=0, err=1.
- Backpressure: XOR A=8'hF0, B=8'h3C with out_ready=0 for 5 cycles -> out_valid stays 1, result=16'h00CC stable, in_ready=0. After out_ready=1 -> transfer; in_ready=1 the next cycle.
- Reset mid-MUL: assert rst 4 edges after accept -> next edge out_valid=0, in_ready=1, all outputs 0. A subsequent ADD 8'h01+8'h02 completes normally with result=16'h0003.
